// File: rtl/opl3_pkg.sv
// rtl/opl3_pkg.sv - shared OPL3 types and constants, including host write-stream payload
package opl3_pkg;

    localparam int HOST_NUM_BANKS     = 2;
    localparam int HOST_FIFO_LG_DEPTH = 4;
    localparam int HOST_DATA_W        = 8;
    localparam int HOST_BANK_W        = (HOST_NUM_BANKS > 1) ? $clog2(HOST_NUM_BANKS) : 1;

    typedef struct packed {
        logic [HOST_BANK_W-1:0] bank;
        logic [HOST_DATA_W-1:0] index;
        logic [HOST_DATA_W-1:0] data;
    } host_wr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILTER,
        ST_COMMIT,
        ST_RELEASE
    } strobe_state_t;

    function automatic int bank_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/host_wr_fifo.sv
// rtl/host_wr_fifo.sv - synchronous first-word-fall-through FIFO for host register writes
module host_wr_fifo #(
    parameter int LG_DEPTH = 4,
    parameter int WIDTH    = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    head,
    output logic                full,
    output logic                empty,
    output logic [LG_DEPTH:0]   count
);

    localparam int DEPTH = 1 << LG_DEPTH;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [LG_DEPTH-1:0] r_wptr;
    logic [LG_DEPTH-1:0] r_rptr;
    logic [LG_DEPTH:0]   r_count;
    logic                w_push;
    logic                w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (LG_DEPTH+1)'(DEPTH));
    assign count  = r_count;
    assign w_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_push = push && (!full || w_pop);
    assign head   = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/host_bus_if_mb.sv
// rtl/host_bus_if_mb.sv - multi-bank host bus interface with filtered strobe and write FIFO
// Optional busy emulation: HOST_BUS_IF_BUSY_EMU_EN
module host_bus_if_mb
    import opl3_pkg::*;
#(
    parameter int NUM_BANKS     = HOST_NUM_BANKS,
    parameter int DATA_WIDTH    = 8,
    parameter int LG_DEPTH      = HOST_FIFO_LG_DEPTH,
    parameter int STROBE_FILTER = 2,
    parameter int ADDR_HOLDOFF  = 4,
    parameter int DATA_HOLDOFF  = 32,
    parameter int BANK_W        = bank_width(NUM_BANKS)
) (
    input  logic                  clk_host,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic [BANK_W:0]       address,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic [DATA_WIDTH-1:0] status,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [BANK_W-1:0]     wr_bank,
    output logic [DATA_WIDTH-1:0] wr_index,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  wait_n
);

    localparam int PAYLOAD_W = BANK_W + 2 * DATA_WIDTH;
    localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W+1)'(NUM_BANKS);

    // Strobe pins are sampled without reset so a strobe held across reset is still seen.
    logic                  r_cs_p1_n;
    logic                  r_wr_p1_n;
    logic [BANK_W:0]       r_address_p1;
    logic [DATA_WIDTH-1:0] r_din_p1;
    logic [DATA_WIDTH-1:0] r_status_p1;
    logic                  w_strobe_p1;

    strobe_state_t         r_state;
    strobe_state_t         w_state_nxt;
    logic [2:0]            r_filt_cnt;
    logic [2:0]            w_filt_cnt_nxt;
    logic                  w_commit;

    logic [DATA_WIDTH-1:0] r_index_latch [NUM_BANKS];
    logic [BANK_W-1:0]     w_bank;
    logic                  w_bank_ok;
    logic                  w_index_commit;
    logic                  w_data_commit;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [PAYLOAD_W-1:0]  w_push_data;
    logic [PAYLOAD_W-1:0]  w_head;
    logic [LG_DEPTH:0]     w_count_unused;
    logic                  w_rd_unused;
    logic                  w_busy;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] w_status_rd;

    assign w_rd_unused = rd_n;

    always_ff @(posedge clk_host) begin
        r_cs_p1_n <= cs_n;
        r_wr_p1_n <= wr_n;
    end

    always_ff @(posedge clk_host) begin
        if (reset) begin
            r_address_p1 <= '1;
            r_din_p1     <= '0;
            r_status_p1  <= '0;
        end else begin
            r_address_p1 <= address;
            r_din_p1     <= din;
            r_status_p1  <= status;
        end
    end

    assign w_strobe_p1 = !r_cs_p1_n && !r_wr_p1_n;

    always_ff @(posedge clk_host) begin
        if (reset) begin
            r_state    <= w_strobe_p1 ? ST_RELEASE : ST_IDLE;
            r_filt_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_filt_cnt <= w_filt_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_filt_cnt_nxt = r_filt_cnt;
        w_commit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe_p1) begin
                    w_state_nxt    = ST_FILTER;
                    w_filt_cnt_nxt = 3'd1;
                end
            end
            ST_FILTER: begin
                if (!w_strobe_p1) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_filt_cnt == 3'(STROBE_FILTER)) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_filt_cnt_nxt = r_filt_cnt + 3'd1;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!w_strobe_p1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_bank         = r_address_p1[BANK_W:1];
    assign w_bank_ok      = ({1'b0, w_bank} < BANK_LIMIT);
    assign w_index_commit = w_commit && w_bank_ok && !r_address_p1[0];
    assign w_data_commit  = w_commit && w_bank_ok && r_address_p1[0];

    always_ff @(posedge clk_host) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_index_latch[b] <= '0;
            end
        end else if (w_index_commit) begin
            r_index_latch[w_bank] <= r_din_p1;
        end
    end

    assign w_pop       = wr_valid && wr_ready;
    assign w_push_data = {w_bank, r_index_latch[w_bank], r_din_p1};

    host_wr_fifo #(
        .LG_DEPTH (LG_DEPTH),
        .WIDTH    (PAYLOAD_W)
    ) u_wr_fifo (
        .clk       (clk_host),
        .reset     (reset),
        .push      (w_data_commit),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count_unused)
    );

    always_ff @(posedge clk_host) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_data_commit && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign wr_valid                     = !w_empty;
    assign {wr_bank, wr_index, wr_data} = w_head;
    assign fifo_full                    = w_full;
    assign overflow                     = r_overflow;

`ifdef HOST_BUS_IF_BUSY_EMU_EN
    localparam int HOLD_MAX = (DATA_HOLDOFF > ADDR_HOLDOFF) ? DATA_HOLDOFF : ADDR_HOLDOFF;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] r_holdoff;

    always_ff @(posedge clk_host) begin
        if (reset) begin
            r_holdoff <= '0;
        end else if (w_data_commit) begin
            r_holdoff <= HOLD_W'(DATA_HOLDOFF);
        end else if (w_index_commit) begin
            r_holdoff <= HOLD_W'(ADDR_HOLDOFF);
        end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - 1'b1;
        end
    end

    assign w_busy = (r_holdoff != '0);
`else
    assign w_busy = 1'b0;
`endif

    assign wait_n = !w_busy && !w_full;

    always_comb begin
        w_status_rd               = r_status_p1;
        w_status_rd[DATA_WIDTH-1] = r_status_p1[DATA_WIDTH-1] | w_busy;
    end

    assign dout = (r_address_p1 == '0) ? w_status_rd : '1;

endmodule

// File: tb/tb_host_bus_if_mb.sv
// tb/tb_host_bus_if_mb.sv - directed self-checking bench for host_bus_if_mb
module tb_host_bus_if_mb;

    logic       clk_host = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] address;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] status;
    logic       wr_valid;
    logic       wr_ready;
    logic [0:0] wr_bank;
    logic [7:0] wr_index;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic       overflow;
    logic       wait_n;

    int tests = 0;
    int fails = 0;

    host_bus_if_mb dut (
        .clk_host  (clk_host),
        .reset     (reset),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .address   (address),
        .din       (din),
        .dout      (dout),
        .status    (status),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_bank   (wr_bank),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .wait_n    (wait_n)
    );

    always #5 clk_host = ~clk_host;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_host);
            @(negedge clk_host);
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        address = a;
        din     = d;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        tick(6);
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        tick(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic pop_one();
        wr_ready = 1'b1;
        tick(1);
        wr_ready = 1'b0;
    endtask

    initial begin
        int lowcnt;
        reset    = 1'b1;
        cs_n     = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        address  = 2'd0;
        din      = 8'h00;
        status   = 8'h00;
        wr_ready = 1'b0;
        @(negedge clk_host);
        tick(3);

        chk("rst_dout", dout, 8'hFF);
        chk("rst_valid", wr_valid, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_wait_n", wait_n, 1'b1);
        chk("rst_fields", {wr_bank, wr_index, wr_data}, 17'h0);
        reset = 1'b0;
        tick(1);

        status  = 8'h5A;
        address = 2'd0;
        tick(2);
        chk("dout_status", dout, 8'h5A);
        address = 2'd2;
        tick(1);
        chk("dout_addr2", dout, 8'hFF);

        // index 0x20 to bank 0, then glitches that must not reach the latch
        host_write(2'b00, 8'h20);
        chk("idx_no_push", wr_valid, 1'b0);
        address = 2'b00;
        din     = 8'h99;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        tick(1);
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        tick(4);
        chk("glitch1_valid", wr_valid, 1'b0);
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        tick(2);
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        tick(4);
        chk("glitch2_valid", wr_valid, 1'b0);

        // data 0x01: wr_valid rises on the 5th rising edge after the strobe is driven
        address = 2'b01;
        din     = 8'h01;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        tick(4);
        chk("lat_early", wr_valid, 1'b0);
        tick(1);
        chk("lat_valid", wr_valid, 1'b1);
        chk("beat1_bank", wr_bank, 1'b0);
        chk("beat1_index", wr_index, 8'h20);
        chk("beat1_data", wr_data, 8'h01);
        tick(1);
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        tick(3);
        chk("hold_valid", wr_valid, 1'b1);
        chk("hold_fields", {wr_bank, wr_index, wr_data}, {1'b0, 8'h20, 8'h01});
        pop_one();
        chk("pop_empty", wr_valid, 1'b0);

        // per-bank index latches
        do_reset();
        host_write(2'b10, 8'h05);
        host_write(2'b01, 8'h40);
        chk("bank0_beat", {wr_bank, wr_index, wr_data}, {1'b0, 8'h00, 8'h40});
        pop_one();
        host_write(2'b11, 8'h77);
        chk("bank1_beat", {wr_bank, wr_index, wr_data}, {1'b1, 8'h05, 8'h77});
        pop_one();
        chk("bank_drained", wr_valid, 1'b0);

        // fill to 16 with back-pressure, 17th overflows
        do_reset();
        host_write(2'b00, 8'h30);
        for (int i = 0; i < 16; i++) begin
            host_write(2'b01, 8'(i));
        end
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_ovf", overflow, 1'b0);
        chk("fill_wait_n", wait_n, 1'b0);
        host_write(2'b01, 8'hEE);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_full", fifo_full, 1'b1);
        wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", wr_valid, 1'b1);
            chk("drain_beat", {wr_bank, wr_index, wr_data}, {1'b0, 8'h30, 8'(i)});
            tick(1);
        end
        wr_ready = 1'b0;
        chk("drain_empty", wr_valid, 1'b0);
        chk("drain_not_full", fifo_full, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // push and pop together on a full FIFO
        do_reset();
        chk("ovf_cleared", overflow, 1'b0);
        for (int i = 0; i < 16; i++) begin
            host_write(2'b01, 8'h80 + 8'(i));
        end
        chk("sim_full", fifo_full, 1'b1);
        address = 2'b01;
        din     = 8'hC5;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        tick(4);
        wr_ready = 1'b1;
        tick(1);
        wr_ready = 1'b0;
        chk("sim_still_full", fifo_full, 1'b1);
        chk("sim_no_ovf", overflow, 1'b0);
        tick(1);
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        tick(3);
        wr_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("sim_drain", wr_data, 8'h80 + 8'(i));
            tick(1);
        end
        chk("sim_last", wr_data, 8'hC5);
        tick(1);
        wr_ready = 1'b0;
        chk("sim_empty", wr_valid, 1'b0);

        // reset in the middle of a held strobe
        do_reset();
        host_write(2'b01, 8'h11);
        chk("mid_pre_valid", wr_valid, 1'b1);
        address = 2'b01;
        din     = 8'h22;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("mid_discard", wr_valid, 1'b0);
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        tick(3);
        chk("mid_no_commit", wr_valid, 1'b0);
        host_write(2'b01, 8'h33);
        chk("mid_recover", {wr_valid, wr_data}, {1'b1, 8'h33});
        pop_one();

`ifdef HOST_BUS_IF_BUSY_EMU_EN
        do_reset();
        wr_ready = 1'b1;
        status   = 8'h00;
        address  = 2'b01;
        din      = 8'h12;
        cs_n     = 1'b0;
        wr_n     = 1'b0;
        lowcnt   = 0;
        for (int c = 0; c < 80; c++) begin
            tick(1);
            if (!wait_n) lowcnt++;
            if (c == 5) begin
                cs_n = 1'b1;
                wr_n = 1'b1;
            end
            if (c == 8) address = 2'b00;
            if (c == 12) chk("busy_bit7", dout[7], 1'b1);
            if (c == 14) address = 2'b10;
            if (c == 20) chk("busy_addr2", dout, 8'hFF);
        end
        wr_ready = 1'b0;
        chk("busy_cycles", lowcnt, 32);
        chk("busy_done", wait_n, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
